// File: rtl/cpu_defs_pkg.sv
// Shared datapath definitions: multiply/divide op encodings (also decoded by the
// control unit) and the multiply/divide sequencer state encodings.
package cpu_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/done handshake and HI/LO result bus between the control unit (master)
// and the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. With i_neg tied to the sign bit it yields
// the magnitude; the most negative value maps to its unsigned magnitude.
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_neg) begin
      o_val = (~i_val) + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply (shift-add) and divide (restoring) unit
// producing HI/LO in WIDTH+1 cycles, with a one-cycle divide-by-zero report.
module mult_div_unit
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  md_state_e        r_state, w_state_d;
  md_op_e           r_op, w_op_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic             r_sa, w_sa_d;
  logic             r_sb, w_sb_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic [W2-1:0]    r_acc, w_acc_d;
  logic [WIDTH-1:0] r_rem, w_rem_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;
  logic             r_done, w_done_d;
  logic             r_div_zero, w_div_zero_d;

  md_op_e           w_op_in;
  logic             w_in_signed;
  logic             w_in_sa;
  logic             w_in_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_op_in     = md_op_e'(md.op);
  assign w_in_signed = md_is_signed(w_op_in);
  assign w_in_sa     = w_in_signed & md.op_a[WIDTH-1];
  assign w_in_sb     = w_in_signed & md.op_b[WIDTH-1];

  md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.i_val(md.op_a), .i_neg(w_in_sa), .o_val(w_abs_a));
  md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.i_val(md.op_b), .i_neg(w_in_sb), .o_val(w_abs_b));

  // Multiply: multiplier sits in the low half of r_acc and shifts out as the
  // partial product shifts in from the top.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  // Divide: dividend shifts out of r_acc's low half while quotient bits shift in.
  logic [WIDTH:0] w_div_shift;
  logic [WIDTH:0] w_div_diff;
  logic           w_q_bit;
  assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_q_bit     = ~w_div_diff[WIDTH];

  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  md_sign_fix #(.WIDTH(W2)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (r_sa ^ r_sb),
    .o_val (w_prod)
  );
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_sa ^ r_sb),
    .o_val (w_quo)
  );
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val (r_rem),
    .i_neg (r_sa),
    .o_val (w_rem)
  );

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_a_d        = r_a;
    w_b_d        = r_b;
    w_sa_d       = r_sa;
    w_sb_d       = r_sb;
    w_cnt_d      = r_cnt;
    w_acc_d      = r_acc;
    w_rem_d      = r_rem;
    w_hi_d       = r_hi;
    w_lo_d       = r_lo;
    w_done_d     = 1'b0;
    w_div_zero_d = 1'b0;

    unique case (r_state)
      MD_IDLE: begin
        if (md.start) begin
          if (md_is_div(w_op_in) && (md.op_b == '0)) begin
            w_done_d     = 1'b1;
            w_div_zero_d = 1'b1;
          end else begin
            w_op_d    = w_op_in;
            w_a_d     = w_abs_a;
            w_b_d     = w_abs_b;
            w_sa_d    = w_in_sa;
            w_sb_d    = w_in_sb;
            w_cnt_d   = CW'(WIDTH);
            w_rem_d   = '0;
            w_acc_d   = md_is_div(w_op_in) ? {{WIDTH{1'b0}}, w_abs_a}
                                           : {{WIDTH{1'b0}}, w_abs_b};
            w_state_d = MD_CALC;
          end
        end
      end

      MD_CALC: begin
        w_cnt_d = r_cnt - CW'(1);
        if (md_is_div(r_op)) begin
          w_rem_d = w_q_bit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
          w_acc_d = {r_acc[W2-1:WIDTH], r_acc[WIDTH-2:0], w_q_bit};
        end else begin
          w_acc_d = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
        if (r_cnt == CW'(1)) begin
          w_state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        w_done_d  = 1'b1;
        w_state_d = MD_IDLE;
        unique case (r_op)
          MD_MULT, MD_MULTU: begin
            w_hi_d = w_prod[W2-1:WIDTH];
            w_lo_d = w_prod[WIDTH-1:0];
          end
          MD_DIV, MD_DIVU: begin
            w_hi_d = w_rem;
            w_lo_d = w_quo;
          end
        endcase
      end

      default: w_state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= MD_IDLE;
      r_op       <= MD_MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_a        <= w_a_d;
      r_b        <= w_b_d;
      r_sa       <= w_sa_d;
      r_sb       <= w_sb_d;
      r_cnt      <= w_cnt_d;
      r_acc      <= w_acc_d;
      r_rem      <= w_rem_d;
      r_hi       <= w_hi_d;
      r_lo       <= w_lo_d;
      r_done     <= w_done_d;
      r_div_zero <= w_div_zero_d;
    end
  end

  assign md.busy     = (r_state != MD_IDLE);
  assign md.done     = r_done;
  assign md.div_zero = r_div_zero;
  assign md.hi       = r_hi;
  assign md.lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8 with hand-computed
// results, latency, busy length, pulse widths, reset and handshake corner cases.
module tb_mult_div_unit;
  import cpu_defs::*;

  logic        clk;
  logic        rst;
  logic        sel8;
  logic        drv_start;
  logic [1:0]  drv_op;
  logic [31:0] drv_a;
  logic [31:0] drv_b;

  logic        m_busy;
  logic        m_done;
  logic        m_dz;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit_if #(.WIDTH(32)) bus32 ();
  mult_div_unit_if #(.WIDTH(8))  bus8 ();

  mult_div_unit #(.WIDTH(32)) u_dut32 (.clock(clk), .reset(rst), .md(bus32));
  mult_div_unit #(.WIDTH(8))  u_dut8  (.clock(clk), .reset(rst), .md(bus8));

  assign bus32.start = drv_start & ~sel8;
  assign bus32.op    = drv_op;
  assign bus32.op_a  = drv_a;
  assign bus32.op_b  = drv_b;
  assign bus8.start  = drv_start & sel8;
  assign bus8.op     = drv_op;
  assign bus8.op_a   = drv_a[7:0];
  assign bus8.op_b   = drv_b[7:0];

  assign m_busy = sel8 ? bus8.busy     : bus32.busy;
  assign m_done = sel8 ? bus8.done     : bus32.done;
  assign m_dz   = sel8 ? bus8.div_zero : bus32.div_zero;
  assign m_hi   = sel8 ? {24'h0, bus8.hi} : bus32.hi;
  assign m_lo   = sel8 ? {24'h0, bus8.lo} : bus32.lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a sample point with the unit idle; returns at the sample point just
  // after the accepting edge, with the operands already scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    drv_start = 1'b1;
    drv_op    = op;
    drv_a     = a;
    drv_b     = b;
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    drv_a     = ~a;
    drv_b     = ~b;
    drv_op    = ~op;
  endtask

  task automatic wait_done(input int max, output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int c = 1; c <= max; c++) begin
      if (m_busy) busy_n++;
      @(posedge clk);
      #1;
      if (m_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input int lat_exp);
    int lat;
    int bn;
    issue(op, a, b);
    wait_done(80, lat, bn);
    check_eq({tag, ":latency"}, 64'(lat), 64'(lat_exp));
    check_eq({tag, ":busy_cycles"}, 64'(bn), 64'(lat_exp));
    check_eq({tag, ":hi"}, 64'(m_hi), 64'(eh));
    check_eq({tag, ":lo"}, 64'(m_lo), 64'(el));
    check_eq({tag, ":div_zero"}, 64'(m_dz), 64'(0));
    @(posedge clk);
    #1;
    check_eq({tag, ":done_width"}, 64'(m_done), 64'(0));
  endtask

  initial begin
    int lat;
    int bn;
    int n_done;

    // Reset held with start asserted: reset must win.
    rst       = 1'b1;
    sel8      = 1'b0;
    drv_start = 1'b1;
    drv_op    = MD_MULTU;
    drv_a     = 32'd3;
    drv_b     = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst:busy", 64'(m_busy), 64'(0));
    check_eq("rst:done", 64'(m_done), 64'(0));
    check_eq("rst:div_zero", 64'(m_dz), 64'(0));
    check_eq("rst:hi", 64'(m_hi), 64'(0));
    check_eq("rst:lo", 64'(m_lo), 64'(0));
    drv_start = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;

    run_check("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_check("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_check("mult_minxmin", MD_MULT, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000, 33);
    run_check("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_check("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_check("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000, 33);
    run_check("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_check("multu_hi1lo2", MD_MULTU, 32'h8000_0001, 32'd2, 32'd1, 32'd2, 33);

    // Divide by zero: immediate one-cycle report, HI/LO untouched.
    issue(MD_DIV, 32'd5, 32'd0);
    check_eq("dz:done", 64'(m_done), 64'(1));
    check_eq("dz:div_zero", 64'(m_dz), 64'(1));
    check_eq("dz:busy", 64'(m_busy), 64'(0));
    check_eq("dz:hi", 64'(m_hi), 64'(1));
    check_eq("dz:lo", 64'(m_lo), 64'(2));
    @(posedge clk);
    #1;
    check_eq("dz:done_width", 64'(m_done), 64'(0));
    check_eq("dz:flag_width", 64'(m_dz), 64'(0));
    check_eq("dz:busy_after", 64'(m_busy), 64'(0));

    // Start pulses while busy must be neither accepted nor queued.
    issue(MD_MULTU, 32'd6, 32'd7);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      drv_start = (c == 5) || (c == 20);
      drv_op    = MD_DIVU;
      drv_a     = 32'd100;
      drv_b     = 32'd3;
      @(posedge clk);
      #1;
      if (m_done) begin
        lat = c;
        break;
      end
    end
    drv_start = 1'b0;
    check_eq("ign:latency", 64'(lat), 64'(33));
    check_eq("ign:hi", 64'(m_hi), 64'(0));
    check_eq("ign:lo", 64'(m_lo), 64'(42));
    @(posedge clk);
    #1;
    check_eq("ign:not_queued", 64'(m_busy), 64'(0));

    // Back-to-back: second start presented in the done cycle.
    issue(MD_DIVU, 32'd9, 32'd4);
    wait_done(80, lat, bn);
    check_eq("b2b1:latency", 64'(lat), 64'(33));
    check_eq("b2b1:hi", 64'(m_hi), 64'(1));
    check_eq("b2b1:lo", 64'(m_lo), 64'(2));
    issue(MD_MULTU, 32'd3, 32'd3);
    check_eq("b2b2:accepted", 64'(m_busy), 64'(1));
    wait_done(80, lat, bn);
    check_eq("b2b2:latency", 64'(lat), 64'(33));
    check_eq("b2b2:hi", 64'(m_hi), 64'(0));
    check_eq("b2b2:lo", 64'(m_lo), 64'(9));
    @(posedge clk);
    #1;

    // Leave nonzero HI/LO, then reset on the 10th CALC cycle.
    run_check("div_7_m2_b", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    issue(MD_MULT, 32'd1234, 32'hFFFF_FF00);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check_eq("rmid:busy_before", 64'(m_busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rmid:busy", 64'(m_busy), 64'(0));
    check_eq("rmid:hi", 64'(m_hi), 64'(0));
    check_eq("rmid:lo", 64'(m_lo), 64'(0));
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_done) n_done++;
      @(posedge clk);
      #1;
    end
    check_eq("rmid:no_done", 64'(n_done), 64'(0));
    check_eq("rmid:hi_held", 64'(m_hi), 64'(0));

    // WIDTH=8 instance.
    sel8 = 1'b1;
    @(posedge clk);
    #1;
    run_check("w8_multu_ff", MD_MULTU, 32'h0000_00FF, 32'h0000_00FF, 32'hFE, 32'h01, 9);
    run_check("w8_div_m7_2", MD_DIV, 32'h0000_00F9, 32'd2, 32'hFF, 32'hFD, 9);
    run_check("w8_div_min_m1", MD_DIV, 32'h0000_0080, 32'h0000_00FF, 32'h00, 32'h80, 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
